lcd_win_ctrl: RTL and testbench

LCD_WIN_CTRL -- requirements
Module: lcd_win_ctrl

---
 rtl/lcd_win_pkg.sv | 30 +++
 rtl/lcd_win_addr.sv | 38 +++
 rtl/lcd_win_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_lcd_win_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_win_pkg.sv
// Shared command codes, mode/state enums and sizing helper for the LCD window
// controller slice.
package lcd_win_pkg;

    localparam logic [2:0] CMD_LOAD     = 3'd0;
    localparam logic [2:0] CMD_ZOOM_IN  = 3'd1;
    localparam logic [2:0] CMD_ZOOM_FIT = 3'd2;
    localparam logic [2:0] CMD_RIGHT    = 3'd3;
    localparam logic [2:0] CMD_LEFT     = 3'd4;
    localparam logic [2:0] CMD_UP       = 3'd5;
    localparam logic [2:0] CMD_DOWN     = 3'd6;
    localparam logic [2:0] CMD_RECENTER = 3'd7;

    typedef enum logic {
        MODE_FIT  = 1'b0,
        MODE_ZOOM = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_OUT
    } state_e;

    // Bit width able to hold 0..n-1, never less than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/lcd_win_addr.sv
// Frame-buffer index for window pixel (row, col): a direct crop in ZOOM mode,
// an evenly decimated grid across the whole image in FIT mode.
module lcd_win_addr #(
    parameter int IMG_W = 12,
    parameter int IMG_H = 9,
    parameter int WIN   = 4,
    parameter int XW    = 4,
    parameter int YW    = 4,
    parameter int RW    = 2,
    parameter int AW    = 7
) (
    input  logic          zoom,
    input  logic [XW-1:0] ox,
    input  logic [YW-1:0] oy,
    input  logic [RW-1:0] row,
    input  logic [RW-1:0] col,
    output logic [AW-1:0] idx
);

    localparam int SX = IMG_W / WIN;
    localparam int SY = IMG_H / WIN;

    logic [AW-1:0] y_pos;
    logic [AW-1:0] x_pos;

    // Every intermediate stays below IMG_W*IMG_H, so AW bits never overflow.
    always_comb begin
        if (zoom) begin
            y_pos = AW'(oy) + AW'(row);
            x_pos = AW'(ox) + AW'(col);
        end else begin
            y_pos = AW'(SY / 2) + AW'(row) * AW'(SY);
            x_pos = AW'(SX / 2) + AW'(col) * AW'(SX);
        end
        idx = y_pos * AW'(IMG_W) + x_pos;
    end

endmodule

// File: rtl/lcd_win_ctrl.sv
// LCD window controller: loads a raster image into a frame buffer and streams a
// WIN x WIN fit/zoom window of it under a valid/ready handshake.
module lcd_win_ctrl
    import lcd_win_pkg::*;
#(
    parameter int DW    = 8,
    parameter int IMG_W = 12,
    parameter int IMG_H = 9,
    parameter int WIN   = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] datain,
    input  logic [2:0]    cmd,
    input  logic          cmd_valid,
    input  logic          out_ready,
    output logic [DW-1:0] dataout,
    output logic          output_valid,
    output logic          busy
);

    localparam int NPIX = IMG_W * IMG_H;
    localparam int AW   = clog2_min1(NPIX);
    localparam int XW   = clog2_min1(IMG_W);
    localparam int YW   = clog2_min1(IMG_H);
    localparam int RW   = clog2_min1(WIN);

    localparam logic [XW-1:0] OX0      = XW'((IMG_W - WIN) / 2);
    localparam logic [YW-1:0] OY0      = YW'((IMG_H - WIN + 1) / 2);
    localparam logic [XW-1:0] OX_MAX   = XW'(IMG_W - WIN);
    localparam logic [YW-1:0] OY_MAX   = YW'(IMG_H - WIN);
    localparam logic [AW-1:0] LAST_IDX = AW'(NPIX - 1);
    localparam logic [RW-1:0] LAST_RC  = RW'(WIN - 1);

    logic [DW-1:0] frame [NPIX];

    state_e        state, state_d;
    mode_e         mode, mode_d;
    logic [XW-1:0] ox, ox_d;
    logic [YW-1:0] oy, oy_d;
    logic [AW-1:0] ld_idx, ld_idx_d;
    logic [RW-1:0] row, row_d;
    logic [RW-1:0] col, col_d;
    logic          warm, warm_d;
    logic          last, last_d;
    logic          valid_d;
    logic [DW-1:0] dataout_d;
    logic          frame_we;
    logic [AW-1:0] rd_idx;

    lcd_win_addr #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .WIN   (WIN),
        .XW    (XW),
        .YW    (YW),
        .RW    (RW),
        .AW    (AW)
    ) u_addr (
        .zoom (mode == MODE_ZOOM),
        .ox   (ox),
        .oy   (oy),
        .row  (row),
        .col  (col),
        .idx  (rd_idx)
    );

    assign busy = (state != ST_IDLE);

    always_comb begin
        // NOTE: every _d signal takes its hold value first, so no branch can infer a latch.
        state_d   = state;
        mode_d    = mode;
        ox_d      = ox;
        oy_d      = oy;
        ld_idx_d  = ld_idx;
        row_d     = row;
        col_d     = col;
        warm_d    = warm;
        last_d    = last;
        valid_d   = output_valid;
        dataout_d = dataout;
        frame_we  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd == CMD_LOAD) begin
                        state_d  = ST_LOAD;
                        ld_idx_d = '0;
                    end else begin
                        state_d = ST_OUT;
                        warm_d  = 1'b1;
                        row_d   = '0;
                        col_d   = '0;
                        last_d  = 1'b0;
                        case (cmd)
                            CMD_ZOOM_IN: begin
                                mode_d = MODE_ZOOM;
                                if (mode == MODE_FIT) begin
                                    ox_d = OX0;
                                    oy_d = OY0;
                                end
                            end
                            CMD_ZOOM_FIT: mode_d = MODE_FIT;
                            CMD_RIGHT:    if (mode == MODE_ZOOM && ox < OX_MAX) ox_d = ox + 1'b1;
                            CMD_LEFT:     if (mode == MODE_ZOOM && ox != '0)    ox_d = ox - 1'b1;
                            CMD_UP:       if (mode == MODE_ZOOM && oy != '0)    oy_d = oy - 1'b1;
                            CMD_DOWN:     if (mode == MODE_ZOOM && oy < OY_MAX) oy_d = oy + 1'b1;
                            CMD_RECENTER: begin
                                if (mode == MODE_ZOOM) begin
                                    ox_d = OX0;
                                    oy_d = OY0;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end

            ST_LOAD: begin
                frame_we = 1'b1;
                if (ld_idx == LAST_IDX) begin
                    state_d = ST_OUT;
                    warm_d  = 1'b1;
                    row_d   = '0;
                    col_d   = '0;
                    last_d  = 1'b0;
                    mode_d  = MODE_FIT;
                    ox_d    = OX0;
                    oy_d    = OY0;
                end else begin
                    ld_idx_d = ld_idx + 1'b1;
                end
            end

            ST_OUT: begin
                // One idle cycle after entry puts the first pixel on the second edge.
                if (warm) begin
                    warm_d = 1'b0;
                end else if (!output_valid || out_ready) begin
                    if (output_valid && last) begin
                        valid_d = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        dataout_d = frame[rd_idx];
                        valid_d   = 1'b1;
                        last_d    = (row == LAST_RC) && (col == LAST_RC);
                        if (col == LAST_RC) begin
                            col_d = '0;
                            row_d = row + 1'b1;
                        end else begin
                            col_d = col + 1'b1;
                        end
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            mode         <= MODE_FIT;
            ox           <= OX0;
            oy           <= OY0;
            ld_idx       <= '0;
            row          <= '0;
            col          <= '0;
            warm         <= 1'b0;
            last         <= 1'b0;
            output_valid <= 1'b0;
            dataout      <= '0;
        end else begin
            state        <= state_d;
            mode         <= mode_d;
            ox           <= ox_d;
            oy           <= oy_d;
            ld_idx       <= ld_idx_d;
            row          <= row_d;
            col          <= col_d;
            warm         <= warm_d;
            last         <= last_d;
            output_valid <= valid_d;
            dataout      <= dataout_d;
        end
    end

    // NOTE: the frame buffer has no reset; its contents are only meaningful after a Load.
    always_ff @(posedge clk) begin
        if (frame_we) frame[ld_idx] <= datain;
    end

endmodule

// File: tb/tb_lcd_win_ctrl.sv
// Self-checking bench for lcd_win_ctrl: directed scenarios with index-valued
// images plus randomized commands, data and backpressure against a window model.
module tb_lcd_win_ctrl;

    localparam int DW    = 8;
    localparam int IMG_W = 12;
    localparam int IMG_H = 9;
    localparam int WIN   = 4;
    localparam int NPIX  = IMG_W * IMG_H;
    localparam int NP    = WIN * WIN;
    localparam int SX    = IMG_W / WIN;
    localparam int SY    = IMG_H / WIN;
    localparam int OX0   = (IMG_W - WIN) / 2;
    localparam int OY0   = (IMG_H - WIN + 1) / 2;
    localparam int MAX_CYC = 400;

    localparam int C_LOAD = 0, C_ZIN = 1, C_ZFIT = 2, C_RIGHT = 3;
    localparam int C_LEFT = 4, C_UP = 5, C_DOWN = 6, C_RECENTER = 7;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] datain = '0;
    logic [2:0]    cmd = '0;
    logic          cmd_valid = 1'b0;
    logic          out_ready = 1'b1;
    logic [DW-1:0] dataout;
    logic          output_valid;
    logic          busy;

    lcd_win_ctrl #(
        .DW    (DW),
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .WIN   (WIN)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .datain       (datain),
        .cmd          (cmd),
        .cmd_valid    (cmd_valid),
        .out_ready    (out_ready),
        .dataout      (dataout),
        .output_valid (output_valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference model: image contents, view mode, origin, and pending window pixels.
    int img [NPIX];
    bit m_zoom = 1'b0;
    int m_ox = OX0;
    int m_oy = OY0;
    int exp_q [$];
    bit load_rand = 1'b0;

    function automatic int pix_index(input bit zoom, input int ox, input int oy, input int r, input int c);
        if (zoom) return (oy + r) * IMG_W + ox + c;
        return (SY / 2 + r * SY) * IMG_W + SX / 2 + c * SX;
    endfunction

    task automatic model_cmd(input int code);
        case (code)
            C_LOAD:     begin m_zoom = 1'b0; m_ox = OX0; m_oy = OY0; end
            C_ZIN:      begin if (!m_zoom) begin m_ox = OX0; m_oy = OY0; end m_zoom = 1'b1; end
            C_ZFIT:     m_zoom = 1'b0;
            C_RIGHT:    if (m_zoom && m_ox < IMG_W - WIN) m_ox++;
            C_LEFT:     if (m_zoom && m_ox > 0) m_ox--;
            C_UP:       if (m_zoom && m_oy > 0) m_oy--;
            C_DOWN:     if (m_zoom && m_oy < IMG_H - WIN) m_oy++;
            default:    if (m_zoom) begin m_ox = OX0; m_oy = OY0; end
        endcase
        for (int r = 0; r < WIN; r++)
            for (int c = 0; c < WIN; c++)
                exp_q.push_back(img[pix_index(m_zoom, m_ox, m_oy, r, c)]);
    endtask

    // Every presented pixel must be the next one the model expects; it is consumed when ready is high.
    always @(negedge clk) begin
        if (reset === 1'b1 && output_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("pixel_expected", 0, 1);
            end else begin
                check("pixel_value", dataout, exp_q[0]);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic junk();
        cmd_valid = 1'($urandom_range(0, 1));
        cmd       = 3'($urandom_range(0, 7));
    endtask

    // ready_mode: 0 always ready, 1 random, 2 stall three cycles on pixel 5 expecting hold_lit.
    task automatic issue(input int code, input int ready_mode, input int hold_lit, output int first_pix);
        int budget;
        int hold_cnt;
        hold_cnt = 0;
        check("idle_before_cmd", busy, 0);
        cmd = 3'(code);
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        check("busy_after_accept", busy, 1);
        junk();
        if (code == C_LOAD) begin
            for (int i = 0; i < NPIX; i++) begin
                img[i] = load_rand ? int'($urandom_range(0, 255)) : i % 256;
                datain = DW'(img[i]);
                out_ready = 1'($urandom_range(0, 1));
                junk();
                @(posedge clk); #1;
            end
            check("busy_through_load", busy, 1);
        end
        model_cmd(code);
        check("valid_low_at_ref", output_valid, 0);
        @(posedge clk); #1;
        junk();
        check("valid_low_first_edge", output_valid, 0);
        @(posedge clk); #1;
        check("valid_second_edge", output_valid, 1);
        first_pix = int'(dataout);
        budget = 0;
        while (busy && budget < MAX_CYC) begin
            if (ready_mode == 2 && (NP - exp_q.size()) == 5 && hold_cnt < 3) begin
                check("hold_value", dataout, hold_lit);
                out_ready = 1'b0;
                hold_cnt++;
            end else if (ready_mode == 1) begin
                out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                out_ready = 1'b1;
            end
            junk();
            @(posedge clk); #1;
            budget++;
        end
        cmd_valid = 1'b0;
        out_ready = 1'b1;
        check("finish_in_budget", budget < MAX_CYC, 1);
        check("valid_drops_with_busy", output_valid, 0);
        check("all_pixels_seen", exp_q.size(), 0);
        if (ready_mode == 2) check("stall_cycles", hold_cnt, 3);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int fp;
        int budget;

        #2;
        check("reset_dataout", dataout, 0);
        check("reset_valid", output_valid, 0);
        check("reset_busy", busy, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // Index-valued image: pin the model's window formulas to hand-computed values.
        for (int i = 0; i < NPIX; i++) img[i] = i;
        check("model_fit_first", pix_index(1'b0, OX0, OY0, 0, 0), 13);
        check("model_fit_row1", pix_index(1'b0, OX0, OY0, 1, 0), 37);
        check("model_fit_last", pix_index(1'b0, OX0, OY0, 3, 3), 94);
        check("model_zoom_first", pix_index(1'b1, OX0, OY0, 0, 0), 40);
        check("model_zoom_last", pix_index(1'b1, OX0, OY0, 3, 3), 79);

        issue(C_LOAD, 0, 0, fp);
        check("load_first", fp, 13);
        issue(C_ZIN, 0, 0, fp);
        check("zoom_in_first", fp, 40);
        for (int k = 0; k < 5; k++) issue(C_RIGHT, 0, 0, fp);
        check("right_clamped", fp, 44);
        for (int k = 0; k < 6; k++) issue(C_UP, 0, 0, fp);
        check("up_clamped", fp, 8);
        issue(C_RECENTER, 0, 0, fp);
        check("recenter_first", fp, 40);
        issue(C_ZFIT, 0, 0, fp);
        check("zoom_fit_first", fp, 13);
        issue(C_LEFT, 1, 0, fp);
        check("left_in_fit", fp, 13);
        issue(C_ZIN, 0, 0, fp);
        check("zoom_in_again", fp, 40);
        issue(C_ZIN, 2, 53, fp);
        check("stalled_first", fp, 40);

        // Abort an output sequence with reset while pixel 7 is on the bus.
        check("idle_before_abort", busy, 0);
        cmd = 3'(C_ZIN);
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        model_cmd(C_ZIN);
        budget = 0;
        while (exp_q.size() > NP - 7 && budget < 50) begin
            @(posedge clk); #1;
            budget++;
        end
        check("reached_pixel7", budget < 50, 1);
        reset = 1'b0;
        #1;
        check("abort_dataout", dataout, 0);
        check("abort_valid", output_valid, 0);
        check("abort_busy", busy, 0);
        exp_q.delete();
        m_zoom = 1'b0;
        m_ox = OX0;
        m_oy = OY0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        issue(C_ZIN, 0, 0, fp);
        check("after_reset_first", fp, 40);

        // Randomized image, command stream and backpressure.
        load_rand = 1'b1;
        issue(C_LOAD, 1, 0, fp);
        for (int k = 0; k < 40; k++) begin
            int code;
            code = int'($urandom_range(0, 7));
            issue(code, 1, 0, fp);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
